// File: rtl/pcpi_mac_pkg.sv
// rtl/pcpi_mac_pkg.sv - shared decode constants, state enum and match helper for the PCPI MAC unit
package pcpi_mac_pkg;

    localparam logic [6:0] MAC_OPCODE = 7'b0001011;
    localparam logic [6:0] MAC_FUNCT7 = 7'b0000000;

    localparam logic [2:0] F3_MAC    = 3'b000;
    localparam logic [2:0] F3_MACCLR = 3'b001;
    localparam logic [2:0] F3_RDACC  = 3'b010;
    localparam logic [2:0] F3_WRACC  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True only for the four claimed instructions; funct3 codes 1xx are left
    // unclaimed so the core's PCPI timeout raises an illegal-instruction trap.
    function automatic logic insn_match(input logic [31:0] insn);
        return (insn[6:0] == MAC_OPCODE) &&
               (insn[31:25] == MAC_FUNCT7) &&
               (insn[14] == 1'b0);
    endfunction

endpackage

// File: rtl/pcpi_mac_if.sv
// rtl/pcpi_mac_if.sv - PCPI handshake bundle between the core (master) and the MAC responder (slave)
interface pcpi_mac_if;

    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );

    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );

endinterface

// File: rtl/pcpi_mac_mul.sv
// rtl/pcpi_mac_mul.sv - start/done 32x32->32 multiplier, iterative by default, single-cycle under PCPI_MAC_FAST_MUL_EN
module pcpi_mac_mul #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [31:0] product
);

`ifdef PCPI_MAC_FAST_MUL_EN

    logic [31:0] prod_q;
    logic        pend_q;

    // Register the full product at start; done follows one cycle later.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prod_q <= 32'd0;
            pend_q <= 1'b0;
        end else begin
            pend_q <= start && !abort;
            if (start) begin
                prod_q <= a * b;
            end
        end
    end

    assign done    = pend_q;
    assign product = prod_q;

`else

    localparam int CW = $clog2(MUL_CYCLES);

    logic [31:0]   mcand_q;
    logic [31:0]   mplier_q;
    logic [31:0]   psum_q;
    logic [CW-1:0] cnt_q;
    logic          run_q;
    logic [31:0]   step_sum;

    // The last step's sum is exposed combinationally so the caller can commit
    // the result on the same edge that performs the final iteration.
    assign step_sum = psum_q + (mplier_q[0] ? mcand_q : 32'd0);
    assign done     = run_q && (cnt_q == CW'(MUL_CYCLES - 1));
    assign product  = step_sum;

    // One shift-add step per cycle while running; only low 32 bits are kept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            psum_q   <= 32'd0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            psum_q   <= 32'd0;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (abort) begin
            run_q <= 1'b0;
        end else if (run_q) begin
            psum_q   <= step_sum;
            mcand_q  <= {mcand_q[30:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[31:1]};
            cnt_q    <= cnt_q + 1'b1;
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

`endif

endmodule

// File: rtl/pcpi_mac_unit.sv
// rtl/pcpi_mac_unit.sv - PCPI custom-0 multiply-accumulate responder (PCPI_MAC_FAST_MUL_EN selects the single-cycle multiplier)
module pcpi_mac_unit
    import pcpi_mac_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        resetn,
    pcpi_mac_if.slave   pcpi,
    output logic        busy
);

    state_t      state_q;
    logic [31:0] acc_q;
    logic [31:0] rd_q;
    logic [2:0]  op_q;
    logic        armed_q;
    logic        ready_q;
    logic        wr_q;

    logic        match;
    logic [2:0]  funct3;
    logic        accept;
    logic        mul_start;
    logic        mul_abort;
    logic        mul_done;
    logic [31:0] mul_product;
    logic [31:0] mul_result;

    assign match  = insn_match(pcpi.pcpi_insn);
    assign funct3 = pcpi.pcpi_insn[14:12];

    // A new instruction is taken only from IDLE and only once valid has been
    // seen low since the last completion, so a held valid cannot re-issue.
    assign accept    = pcpi.pcpi_valid && match && armed_q && (state_q == ST_IDLE);
    assign mul_start = accept && (funct3 == F3_MAC || funct3 == F3_MACCLR);
    assign mul_abort = (state_q == ST_MUL) && !pcpi.pcpi_valid;

    assign mul_result = (op_q == F3_MAC) ? (acc_q + mul_product) : mul_product;

    pcpi_mac_mul #(
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .resetn  (resetn),
        .start   (mul_start),
        .abort   (mul_abort),
        .a       (pcpi.pcpi_rs1),
        .b       (pcpi.pcpi_rs2),
        .done    (mul_done),
        .product (mul_product)
    );

    // Control FSM, accumulator and registered PCPI response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            acc_q   <= 32'd0;
            rd_q    <= 32'd0;
            op_q    <= F3_MAC;
            armed_q <= 1'b1;
            ready_q <= 1'b0;
            wr_q    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            wr_q    <= 1'b0;
            if (!pcpi.pcpi_valid) begin
                armed_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        busy <= 1'b1;
                        case (funct3)
                            F3_RDACC: begin
                                rd_q    <= acc_q;
                                ready_q <= 1'b1;
                                wr_q    <= 1'b1;
                                state_q <= ST_DONE;
                            end
                            F3_WRACC: begin
                                rd_q    <= acc_q;
                                acc_q   <= pcpi.pcpi_rs1;
                                ready_q <= 1'b1;
                                wr_q    <= 1'b1;
                                state_q <= ST_DONE;
                            end
                            default: begin
                                op_q    <= funct3;
                                state_q <= ST_MUL;
                            end
                        endcase
                    end
                end
                ST_MUL: begin
                    if (!pcpi.pcpi_valid) begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (mul_done) begin
                        acc_q   <= mul_result;
                        rd_q    <= mul_result;
                        ready_q <= 1'b1;
                        wr_q    <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    armed_q <= !pcpi.pcpi_valid;
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Wait is combinational so the core's timeout is suppressed from cycle 0.
    assign pcpi.pcpi_wait  = resetn && pcpi.pcpi_valid && match && (state_q != ST_DONE);
    assign pcpi.pcpi_ready = ready_q;
    assign pcpi.pcpi_wr    = wr_q;
    assign pcpi.pcpi_rd    = rd_q;

endmodule

// File: tb/tb_pcpi_mac_unit.sv
// tb/tb_pcpi_mac_unit.sv - randomized self-checking bench for pcpi_mac_unit against a behavioural accumulator model
module tb_pcpi_mac_unit;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic busy;

    pcpi_mac_if bus ();

    pcpi_mac_unit #(
        .MUL_CYCLES (32)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .pcpi   (bus),
        .busy   (busy)
    );

    always #5 clk = ~clk;

`ifdef PCPI_MAC_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_acc = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 10'd0, f3, 5'd1, 7'b0001011};
    endfunction

    // Architectural model: accumulator semantics in plain modular arithmetic.
    task automatic model_exec(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] rd);
        longint unsigned full;
        longint unsigned prod;
        longint unsigned sum;
        full = longint'(a) * longint'(b);
        prod = full % 64'h1_0000_0000;
        rd   = 32'd0;
        case (f3)
            3'd0: begin
                sum = (longint'(model_acc) + prod) % 64'h1_0000_0000;
                model_acc = sum[31:0];
                rd = model_acc;
            end
            3'd1: begin
                model_acc = prod[31:0];
                rd = model_acc;
            end
            3'd2: rd = model_acc;
            default: begin
                rd = model_acc;
                model_acc = a;
            end
        endcase
    endtask

    task automatic run_insn(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input bit hold_extra);
        logic [31:0] exp_rd;
        int          lat;
        int          exp_lat;
        bit          wait_ok;
        bit          extra_ok;
        model_exec(f3, a, b, exp_rd);
        exp_lat = (f3 == 3'd2 || f3 == 3'd3) ? 1 : MUL_LAT;
        bus.pcpi_insn  = mk_insn(7'd0, f3);
        bus.pcpi_rs1   = a;
        bus.pcpi_rs2   = b;
        bus.pcpi_valid = 1'b1;
        #1;
        check("wait_cycle0", bus.pcpi_wait, 1);
        lat = -1;
        wait_ok = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.pcpi_ready) begin
                lat = k;
                break;
            end
            if (!bus.pcpi_wait) wait_ok = 1'b0;
        end
        check("latency", lat, exp_lat);
        check("wait_held", wait_ok, 1);
        if (lat > 0) begin
            check("wr_with_ready", bus.pcpi_wr, 1);
            check("rd", bus.pcpi_rd, exp_rd);
            check("wait_in_done", bus.pcpi_wait, 0);
        end
        @(negedge clk);
        check("ready_one_cycle", bus.pcpi_ready, 0);
        check("rd_hold", bus.pcpi_rd, exp_rd);
        if (hold_extra) begin
            extra_ok = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (bus.pcpi_ready || bus.pcpi_wr || busy) extra_ok = 1'b0;
            end
            check("no_reissue_held_valid", extra_ok, 1);
        end
        bus.pcpi_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_illegal(input logic [6:0] f7, input logic [2:0] f3, input int cycles);
        bit any_wait;
        bit any_ready;
        bit any_wr;
        bus.pcpi_insn  = mk_insn(f7, f3);
        bus.pcpi_rs1   = $urandom;
        bus.pcpi_rs2   = $urandom;
        bus.pcpi_valid = 1'b1;
        any_wait = 1'b0;
        any_ready = 1'b0;
        any_wr = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            #1;
            any_wait  |= bus.pcpi_wait;
            any_ready |= bus.pcpi_ready;
            any_wr    |= bus.pcpi_wr;
            @(negedge clk);
        end
        check("illegal_wait", any_wait, 0);
        check("illegal_ready", any_ready, 0);
        check("illegal_wr", any_wr, 0);
        bus.pcpi_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_abort(input logic [31:0] a, input logic [31:0] b);
        bit saw_ready;
        bus.pcpi_insn  = mk_insn(7'd0, 3'd0);
        bus.pcpi_rs1   = a;
        bus.pcpi_rs2   = b;
        bus.pcpi_valid = 1'b1;
        saw_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            saw_ready |= bus.pcpi_ready;
        end
        bus.pcpi_valid = 1'b0;
        @(negedge clk);
        check("abort_no_ready", saw_ready | bus.pcpi_ready, 0);
        check("abort_busy_low", busy, 0);
    endtask

    task automatic run_reset_in_mul(input logic [31:0] a, input logic [31:0] b);
        bus.pcpi_insn  = mk_insn(7'd0, 3'd0);
        bus.pcpi_rs1   = a;
        bus.pcpi_rs2   = b;
        bus.pcpi_valid = 1'b1;
        for (int k = 1; k <= 5; k++) @(negedge clk);
        check("busy_before_reset", busy, 1);
        resetn = 1'b0;
        #1;
        check("rst_rd", bus.pcpi_rd, 0);
        check("rst_ready", bus.pcpi_ready, 0);
        check("rst_wr", bus.pcpi_wr, 0);
        check("rst_busy", busy, 0);
        check("rst_wait", bus.pcpi_wait, 0);
        bus.pcpi_valid = 1'b0;
        model_acc = 32'd0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bus.pcpi_valid = 1'b0;
        bus.pcpi_insn  = 32'd0;
        bus.pcpi_rs1   = 32'd0;
        bus.pcpi_rs2   = 32'd0;
        #1;
        check("reset_rd", bus.pcpi_rd, 0);
        check("reset_ready", bus.pcpi_ready, 0);
        check("reset_wr", bus.pcpi_wr, 0);
        check("reset_busy", busy, 0);
        bus.pcpi_insn  = mk_insn(7'd0, 3'd2);
        bus.pcpi_valid = 1'b1;
        #1;
        check("reset_wait", bus.pcpi_wait, 0);
        bus.pcpi_valid = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        run_insn(3'd1, 32'd3, 32'd5, 1'b0);
        run_insn(3'd0, 32'd4, 32'd6, 1'b0);
        run_insn(3'd3, 32'hFFFF_FFF0, 32'd0, 1'b0);
        run_insn(3'd0, 32'h10, 32'd1, 1'b0);
        run_insn(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_insn(3'd2, 32'd0, 32'd0, 1'b1);

        run_illegal(7'd0, 3'b111, 20);
        run_illegal(7'd1, 3'b000, 6);
        run_insn(3'd2, 32'd0, 32'd0, 1'b0);

        run_abort($urandom, $urandom);
        run_insn(3'd2, 32'd0, 32'd0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] b;
            f3 = 3'($urandom_range(0, 3));
            a  = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
            b  = (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
            run_insn(f3, a, b, bit'($urandom_range(0, 1)));
        end

        run_insn(3'd1, 32'd7, 32'd9, 1'b0);
        run_reset_in_mul(32'd11, 32'd13);
        run_insn(3'd2, 32'd0, 32'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
